exe_muldiv_ctrl: RTL
====================

EXE_MULDIV_CTRL -- requirements
Module: exe_muldiv_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 63, meaning the maximum cycles spent in WAIT/DRAIN before an abort.
REQ-002 SHALL have parameter DIVZ_RESULT, default 32'hFFFF_FFFF, meaning the result returned for a divide by zero.
REQ-003 SHALL have port clk  in  1  the single clock; all flops rise-edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  EXE holds a mul/div instruction.
REQ-006 SHALL have port req_op  in  1  0 = multiply, 1 = divide.
REQ-007 SHALL have ports req_a, req_b  in  32  operands; req_b is the divisor.
REQ-008 SHALL have port req_rd  in  5  destination register tag.
REQ-009 SHALL have port flush  in  1  pipeline flush; the current instruction is killed.
REQ-010 SHALL have port unit_valid  in  1  result-ready pulse from the mul/div unit.
REQ-011 SHALL have port unit_result  in  32  result from the mul/div unit.
REQ-012 SHALL have ports unit_start (1), unit_op (1), unit_a (32), unit_b (32)  out  issue to the mul/div unit.
REQ-013 SHALL have port stall  out  1  freeze IF/ID/EXE.
REQ-014 SHALL have ports wb_valid (1), wb_rd (5), wb_data (32), wb_err (1)  out  writeback.

Function
REQ-015 SHALL implement the states IDLE, ISSUE, WAIT, DONE and DRAIN.
REQ-016 In IDLE, req_valid & !flush SHALL register op, a, b and rd, then go to DONE if (req_op=1 & req_b=0), else to ISSUE.
REQ-017 A divide by zero SHALL never assert unit_start, and SHALL return wb_data = DIVZ_RESULT with wb_err = 0.
REQ-018 In ISSUE, unit_start SHALL be 1 for exactly one cycle, with registered unit_op/a/b; the next state SHALL be WAIT (DRAIN if flush).
REQ-019 unit_op/a/b SHALL hold their registered values from ISSUE until the next issue.
REQ-020 In WAIT, unit_valid SHALL capture unit_result into wb_data and transition to DONE.
REQ-021 unit_valid SHALL be ignored in IDLE, ISSUE and DONE.
REQ-022 A wait counter SHALL clear on entry to WAIT and increment each WAIT/DRAIN cycle.
REQ-023 When the wait counter reaches TIMEOUT without unit_valid, the block SHALL go to DONE with wb_data = 0 and wb_err = 1 (from WAIT), or to IDLE (from DRAIN).
REQ-024 In DONE, wb_valid SHALL be 1 for one cycle, qualified by !flush, with wb_rd = the registered rd; the next state SHALL be IDLE.
REQ-025 stall SHALL be 1 in IDLE when req_valid & !flush, and 1 in ISSUE, WAIT and DRAIN.
REQ-026 stall SHALL be 0 in DONE, so that EXE advances in the same cycle wb_valid pulses.
REQ-027 flush in WAIT SHALL move the block to DRAIN, because the unit cannot be aborted.
REQ-028 DRAIN SHALL wait for unit_valid, discard the result, then return to IDLE; no wb_valid SHALL be produced.
REQ-029 flush in DRAIN SHALL have no effect.
REQ-030 flush coincident with unit_valid in WAIT SHALL take the DRAIN branch and discard the result, returning to IDLE next cycle.
REQ-031 A new request SHALL be accepted no earlier than the cycle after DONE; the minimum issue-to-issue spacing is unit latency + 3 cycles.

Reset
REQ-032 rst SHALL force state IDLE immediately, asynchronously, at any point including mid-operation.
REQ-033 On reset, all outputs SHALL be 0 and the wait counter SHALL be 0.
REQ-034 On reset, the registered op/a/b/rd SHALL be 0.
REQ-035 The mul/div unit SHALL share rst, so no DRAIN is needed after reset.

Structure
REQ-036 A shared package SHALL hold the state encoding (3-bit enum), the op encoding (MUL=0, DIV=1) and DIVZ_RESULT.
REQ-037 The block SHALL be a single module with no sub-modules; the wait counter SHALL be sized $clog2(TIMEOUT+1).

Verification
REQ-038 Scenario: MUL a=7, b=6, unit_valid 10 cycles after start -> start for 1 cycle, stall for 12 cycles, wb_valid with wb_data=42, wb_rd held.
REQ-039 Scenario: DIV a=100, b=0 -> no unit_start, stall for 1 cycle, DONE next cycle with wb_data=FFFF_FFFF and wb_err=0.
REQ-040 Scenario: DIV 100/7 with flush on WAIT cycle 5 and unit_valid at 40 -> DRAIN until unit_valid, then IDLE, no wb_valid, stall=0 after.
REQ-041 Scenario: MUL with unit_valid never asserted -> wb_valid with wb_err=1 and wb_data=0 after exactly 63 WAIT cycles.
REQ-042 Scenario: two back-to-back MULs (3*5, then 4*4) -> the second start follows the first DONE by 2 cycles; results 15, then 16.
REQ-043 Scenario: rst asserted in WAIT -> state IDLE and all outputs 0 the same cycle; a late unit_valid afterwards is ignored.

Source files
------------

// File: rtl/exe_muldiv_ctrl_pkg.sv
// Shared encodings for the EXE-stage multiply/divide controller.
package exe_muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    localparam logic [31:0] DIVZ_RESULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/exe_muldiv_ctrl.sv
// EXE-stage sequencer for a multi-cycle mul/div unit: issues one operation,
// stalls the front of the pipe, handles flush/drain and timeout, writes back.
module exe_muldiv_ctrl #(
    parameter int          TIMEOUT     = 63,
    parameter logic [31:0] DIVZ_RESULT = exe_muldiv_ctrl_pkg::DIVZ_RESULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    input  logic        unit_valid,
    input  logic [31:0] unit_result,
    output logic        unit_start,
    output logic        unit_op,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_err
);
    import exe_muldiv_ctrl_pkg::*;

    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

    state_e         state_q;
    logic           op_q;
    logic [31:0]    a_q;
    logic [31:0]    b_q;
    logic [4:0]     rd_q;
    logic [31:0]    data_q;
    logic           err_q;
    logic [CW-1:0]  wcnt_q;
    logic [CW-1:0]  wcnt_d;
    logic           timeout_hit;
    logic           accept;
    logic           divz;

    assign accept      = req_valid && !flush;
    assign divz        = (req_op == OP_DIV) && (req_b == 32'd0);
    assign wcnt_d      = wcnt_q + CW'(1);
    // ">=" so a count carried from WAIT into DRAIN still terminates.
    assign timeout_hit = (wcnt_q >= TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rd_q  <= req_rd;
                        err_q <= 1'b0;
                        // Divide by zero bypasses the unit, so the issue operands stay untouched.
                        if (divz) begin
                            data_q  <= DIVZ_RESULT;
                            state_q <= S_DONE;
                        end else begin
                            op_q    <= req_op;
                            a_q     <= req_a;
                            b_q     <= req_b;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    wcnt_q  <= '0;
                    state_q <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    wcnt_q <= wcnt_d;
                    if (flush) begin
                        // A result arriving with the flush is already the one to discard.
                        state_q <= unit_valid ? S_IDLE : S_DRAIN;
                    end else if (unit_valid) begin
                        data_q  <= unit_result;
                        err_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else if (timeout_hit) begin
                        data_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DRAIN: begin
                    wcnt_q <= wcnt_d;
                    if (unit_valid || timeout_hit) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign unit_start = (state_q == S_ISSUE);
    assign unit_op    = op_q;
    assign unit_a     = a_q;
    assign unit_b     = b_q;

    // DONE releases the stall so EXE advances in the writeback cycle.
    assign stall = ((state_q == S_IDLE) && accept) ||
                   (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_DRAIN);

    assign wb_valid = (state_q == S_DONE) && !flush;
    assign wb_rd    = rd_q;
    assign wb_data  = data_q;
    assign wb_err   = err_q;

endmodule
